// File: rtl/brushless_ctrl.sv
// Six-step brushless motor commutation controller: synchronised hall decode,
// IDLE/RUN/BRAKE/FAULT mode FSM and a prescaled PWM duty ramp.
module brushless_ctrl #(
    parameter int RAMP_DIV = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        brake_n,
    input  logic [11:0] drv_mag,
    input  logic        hallGrn,
    input  logic        hallYlw,
    input  logic        hallBlu,
    output logic [10:0] duty,
    output logic [1:0]  selGrn,
    output logic [1:0]  selYlw,
    output logic [1:0]  selBlu,
    output logic        fault,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BRAKE = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [10:0] DUTY_RUN_START = 11'h400;
    localparam logic [10:0] DUTY_BRAKE     = 11'h600;
    localparam logic [5:0]  SEL_OFF        = 6'b00_00_00;
    localparam logic [5:0]  SEL_BRAKE      = 6'b11_11_11;

    state_t                state_q, state_d;
    logic [2:0]            hall_meta_q;
    logic [2:0]            rot_q;
    logic [10:0]           duty_q;
    logic [5:0]            sel_q;
    logic                  fault_q;
    logic                  ill_q;
    logic [RAMP_DIV-1:0]   presc_q;

    logic                  rot_legal;
    logic [5:0]            sel_dec;
    logic [10:0]           target;
    logic                  presc_tick;
    logic [10:0]           duty_ramp;
    logic                  run_entry;
    logic                  drv_lsb_unused;

    // The two magnitude LSBs are below the duty resolution.
    assign drv_lsb_unused = ^drv_mag[1:0];

    assign rot_legal  = (rot_q != 3'b000) && (rot_q != 3'b111);
    assign target     = DUTY_RUN_START + {1'b0, drv_mag[11:2]};
    assign presc_tick = &presc_q;
    assign run_entry  = (state_d == RUN) && (state_q != RUN);

    // Commutation table, packed as {Grn, Ylw, Blu}; 10 = forward, 01 = reverse.
    always_comb begin
        sel_dec = SEL_OFF;
        case (rot_q)
            3'b101:  sel_dec = 6'b10_01_00;
            3'b100:  sel_dec = 6'b10_00_01;
            3'b110:  sel_dec = 6'b00_10_01;
            3'b010:  sel_dec = 6'b01_10_00;
            3'b011:  sel_dec = 6'b01_00_10;
            3'b001:  sel_dec = 6'b00_01_10;
            default: sel_dec = SEL_OFF;
        endcase
    end

    always_comb begin
        duty_ramp = duty_q;
        if (presc_tick) begin
            if (duty_q < target) begin
                duty_ramp = duty_q + 11'd1;
            end else if (duty_q > target) begin
                duty_ramp = duty_q - 11'd1;
            end
        end
    end

    // FAULT is sticky until enable drops; a lone illegal hall sample in RUN
    // is tolerated, a second consecutive one is not.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    if (!brake_n) begin
                        state_d = BRAKE;
                    end else if (rot_legal) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (!rot_legal && ill_q) begin
                    state_d = FAULT;
                end else if (!brake_n) begin
                    state_d = BRAKE;
                end
            end
            BRAKE: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (brake_n && rot_legal) begin
                    state_d = RUN;
                end
            end
            FAULT: begin
                if (!enable) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hall_meta_q <= 3'b000;
            rot_q       <= 3'b000;
            duty_q      <= 11'h000;
            sel_q       <= SEL_OFF;
            fault_q     <= 1'b0;
            ill_q       <= 1'b0;
            presc_q     <= '0;
        end else begin
            hall_meta_q <= {hallGrn, hallYlw, hallBlu};
            rot_q       <= hall_meta_q;
            state_q     <= state_d;
            fault_q     <= (state_d == FAULT);
            ill_q       <= (state_q == RUN) && (state_d == RUN) && !rot_legal;

            if (run_entry) begin
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + RAMP_DIV'(1);
            end

            case (state_d)
                RUN: begin
                    duty_q <= run_entry ? DUTY_RUN_START : duty_ramp;
                    if (rot_legal) begin
                        sel_q <= sel_dec;
                    end
                end
                BRAKE: begin
                    duty_q <= DUTY_BRAKE;
                    sel_q  <= SEL_BRAKE;
                end
                default: begin
                    duty_q <= 11'h000;
                    sel_q  <= SEL_OFF;
                end
            endcase
        end
    end

    assign duty    = duty_q;
    assign selGrn  = sel_q[5:4];
    assign selYlw  = sel_q[3:2];
    assign selBlu  = sel_q[1:0];
    assign fault   = fault_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_brushless_ctrl.sv
// Directed bench for brushless_ctrl: mode transitions, commutation latency,
// illegal-hall filtering, duty ramp timing and asynchronous reset.
module tb_brushless_ctrl;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_BRAKE = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        brake_n;
    logic [11:0] drv_mag;
    logic        hallGrn, hallYlw, hallBlu;

    logic [10:0] duty, duty_f;
    logic [1:0]  selGrn, selYlw, selBlu;
    logic [1:0]  selGrn_f, selYlw_f, selBlu_f;
    logic        fault, fault_f;
    logic [1:0]  state, state_f;

    int n_checks = 0;
    int n_pass   = 0;

    brushless_ctrl #(.RAMP_DIV(6)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .brake_n(brake_n),
        .drv_mag(drv_mag), .hallGrn(hallGrn), .hallYlw(hallYlw), .hallBlu(hallBlu),
        .duty(duty), .selGrn(selGrn), .selYlw(selYlw), .selBlu(selBlu),
        .fault(fault), .state_o(state)
    );

    // Short-prescaler copy so a mid-ramp duty of 11'h500 is reached quickly.
    brushless_ctrl #(.RAMP_DIV(2)) dut_fast (
        .clk(clk), .rst_n(rst_n), .enable(enable), .brake_n(brake_n),
        .drv_mag(drv_mag), .hallGrn(hallGrn), .hallYlw(hallYlw), .hallBlu(hallBlu),
        .duty(duty_f), .selGrn(selGrn_f), .selYlw(selYlw_f), .selBlu(selBlu_f),
        .fault(fault_f), .state_o(state_f)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_hall(input logic [2:0] v);
        {hallGrn, hallYlw, hallBlu} = v;
    endtask

    function automatic logic [5:0] sels();
        return {selGrn, selYlw, selBlu};
    endfunction

    logic [2:0] hall_seq [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
    logic [5:0] sel_seq  [6] = '{6'b10_00_01, 6'b00_10_01, 6'b01_10_00,
                                 6'b01_00_10, 6'b00_01_10, 6'b10_01_00};

    initial begin
        rst_n = 1'b0; enable = 1'b0; brake_n = 1'b1; drv_mag = 12'h000;
        set_hall(3'b000);
        #12;
        check("reset_duty",  duty,   11'h000);
        check("reset_sels",  sels(), 6'h00);
        check("reset_fault", fault,  1'b0);
        check("reset_state", state,  S_IDLE);

        // Enter RUN: two sync flops, then the FSM sees rot=101.
        set_hall(3'b101); enable = 1'b1; rst_n = 1'b1;
        tick(2);
        check("sync_wait_idle", state, S_IDLE);
        tick(1);
        check("run_state", state,  S_RUN);
        check("run_sels",  sels(), 6'b10_01_00);
        check("run_duty",  duty,   11'h400);
        drv_mag = 12'hFFF;
        tick(63);
        check("ramp_hold_63", duty, 11'h400);
        tick(1);
        check("ramp_step_64", duty, 11'h401);

        // Commutation: each pattern lands exactly 3 clocks after the hall edge.
        for (int i = 0; i < 6; i++) begin
            set_hall(hall_seq[i]);
            tick(2);
            check("comm_before", sels(), (i == 0) ? 6'b10_01_00 : sel_seq[i-1]);
            tick(1);
            check("comm_after", sels(), sel_seq[i]);
        end

        brake_n = 1'b0;
        tick(1);
        check("brake_state", state,  S_BRAKE);
        check("brake_sels",  sels(), 6'h3F);
        check("brake_duty",  duty,   11'h600);
        tick(3);
        check("brake_hold", duty, 11'h600);
        brake_n = 1'b1;
        tick(1);
        check("rerun_state", state,  S_RUN);
        check("rerun_duty",  duty,   11'h400);
        check("rerun_sels",  sels(), 6'b10_01_00);
        tick(63);
        check("rerun_hold_63", duty, 11'h400);
        tick(1);
        check("rerun_step_64", duty, 11'h401);

        // Full ramp to the 11'h7FF ceiling: 1023 steps of 64 clocks.
        tick(65407);
        check("ramp_7fe", duty, 11'h7FE);
        tick(1);
        check("ramp_7ff", duty, 11'h7FF);
        tick(256);
        check("ramp_ceiling_hold", duty, 11'h7FF);
        drv_mag = 12'h000;
        tick(63);
        check("ramp_down_wait", duty, 11'h7FF);
        tick(1);
        check("ramp_down_step", duty, 11'h7FE);

        // Single illegal sample: sels held, then next legal pattern applied.
        set_hall(3'b111);
        tick(1);
        set_hall(3'b100);
        tick(2);
        check("glitch_sels_held", sels(), 6'b10_01_00);
        check("glitch_no_fault",  fault,  1'b0);
        check("glitch_state",     state,  S_RUN);
        tick(1);
        check("glitch_recover_sels", sels(), 6'b10_00_01);

        // Two consecutive illegal samples trip FAULT.
        set_hall(3'b000);
        tick(3);
        check("ill1_state", state,  S_RUN);
        check("ill1_sels",  sels(), 6'b10_00_01);
        tick(1);
        check("fault_state", state,  S_FAULT);
        check("fault_flag",  fault,  1'b1);
        check("fault_sels",  sels(), 6'h00);
        check("fault_duty",  duty,   11'h000);
        set_hall(3'b101); brake_n = 1'b0;
        tick(4);
        check("fault_sticky", state, S_FAULT);
        check("fault_sticky_flag", fault, 1'b1);
        enable = 1'b0;
        tick(1);
        check("fault_exit_idle", state, S_IDLE);
        check("fault_exit_flag", fault, 1'b0);

        // IDLE -> BRAKE, then asynchronous reset mid-BRAKE.
        enable = 1'b1;
        tick(1);
        check("idle_to_brake", state,  S_BRAKE);
        check("idle_brake_sels", sels(), 6'h3F);
        rst_n = 1'b0;
        #1;
        check("rst_brake_state", state,  S_IDLE);
        check("rst_brake_sels",  sels(), 6'h00);
        check("rst_brake_duty",  duty,   11'h000);
        #2;
        rst_n = 1'b1; brake_n = 1'b1; drv_mag = 12'hFFF;
        tick(1);
        check("post_rst_idle", state, S_IDLE);
        tick(2);
        check("post_rst_run", state, S_RUN);
        check("post_rst_duty", duty, 11'h400);

        // Ramp the fast copy to 11'h500, then pull reset between edges.
        tick(1024);
        check("fast_mid_ramp", duty_f, 11'h500);
        check("slow_mid_ramp", duty,   11'h410);
        rst_n = 1'b0;
        #1;
        check("async_rst_duty_f",  duty_f, 11'h000);
        check("async_rst_sels_f",  {selGrn_f, selYlw_f, selBlu_f}, 6'h00);
        check("async_rst_fault_f", fault_f, 1'b0);
        check("async_rst_state_f", state_f, S_IDLE);
        check("async_rst_duty",    duty,   11'h000);
        check("async_rst_sels",    sels(), 6'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/brushless_ctrl.md
BRUSHLESS_CTRL -- requirements
Module: brushless_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port enable, input, 1, rider/system drive enable.
REQ-004 SHALL have port brake_n, input, 1, active-low brake request.
REQ-005 SHALL have port drv_mag, input, 12, requested drive magnitude, unsigned.
REQ-006 SHALL have ports hallGrn, hallYlw, hallBlu, input, 1 each, raw asynchronous hall sensors.
REQ-007 SHALL have port duty, output, 11, PWM duty to motor driver.
REQ-008 SHALL have ports selGrn, selYlw, selBlu, output, 2 each, phase select to motor driver:
- 00 off
- 01 reverse current
- 10 forward current
- 11 brake
REQ-009 SHALL have port fault, output, 1, illegal-hall fault flag.
REQ-010 SHALL have parameter RAMP_DIV, default 6, log2 of clocks per duty ramp step.

Function
REQ-011 SHALL double-flop each hall input; rot = {hallGrn,hallYlw,hallBlu} after sync.
REQ-012 SHALL register all outputs; hall edge to sel change latency = 3 clocks in RUN.
REQ-013 SHALL implement FSM with states IDLE, RUN, BRAKE, FAULT.
REQ-014 SHALL transition priority per clock:
- FAULT held
- else !enable -> IDLE
- else illegal rot in RUN -> FAULT
- else brake_n rule
REQ-015 SHALL go IDLE->RUN when enable=1, brake_n=1 and rot legal; IDLE->BRAKE when enable=1, brake_n=0.
REQ-016 SHALL go RUN->BRAKE when brake_n=0; BRAKE->RUN when brake_n=1 and rot legal.
REQ-017 SHALL go RUN->FAULT when rot is 000 or 111 for 2 consecutive clocks; a single-clock illegal sample holds previous sels.
REQ-018 SHALL leave FAULT only to IDLE, only when enable=0.
REQ-019 SHALL drive sels {Grn,Ylw,Blu} in RUN from rot:
- 101 -> 10,01,00
- 100 -> 10,00,01
- 110 -> 00,10,01
- 010 -> 01,10,00
- 011 -> 01,00,10
- 001 -> 00,01,10
REQ-020 SHALL drive all sels 00 in IDLE and FAULT; all sels 11 in BRAKE.
REQ-021 SHALL compute target = 11'h400 + drv_mag[11:2] (10-bit add, no overflow, max 11'h7FF).
REQ-022 SHALL, in RUN, step duty by exactly 1 toward target once per 2^RAMP_DIV clocks (free-running prescaler), holding when equal.
REQ-023 SHALL load duty = 11'h400 on every entry to RUN, with prescaler cleared.
REQ-024 SHALL hold duty = 11'h600 in BRAKE and 11'h000 in IDLE and FAULT.
REQ-025 SHALL assert fault=1 only in FAULT.

Reset
REQ-026 SHALL, on rst_n=0, immediately set:
- state IDLE
- duty 11'h000
- all sels 00
- fault 0
- sync flops 0
- prescaler 0
REQ-027 SHALL treat reset mid-RUN or mid-BRAKE identically; first post-reset clock evaluates from IDLE.

Verification
REQ-028 SHALL cover: reset, enable=1, brake_n=1, rot=101 -> RUN; sels 10,01,00; duty 11'h400.
REQ-029 SHALL cover: RUN, drv_mag=12'hFFF, RAMP_DIV=6 -> duty rises 1 per 64 clocks, stops at 11'h7FF.
REQ-030 SHALL cover: RUN, rot steps 101->100->110->010->011->001 -> each sel pattern appears 3 clocks after the hall change.
REQ-031 SHALL cover: RUN, brake_n=0 -> all sels 11, duty 11'h600; brake_n=1 -> RUN, duty restarts 11'h400.
REQ-032 SHALL cover: RUN, rot=111 for 1 clock -> sels held, fault=0; rot=000 for 2 clocks -> FAULT, sels 00, fault=1 until enable=0 -> IDLE.
REQ-033 SHALL cover: rst_n pulsed low asynchronously mid-ramp at duty 11'h500 -> outputs zero before the next clock edge.
